// File: rtl/uc_mc.sv
// uc_mc: instruction sequencing controller.
// Fetches an opcode, decodes it into an ALU operation, runs single- or multi-cycle
// execution with a bounded wait on alu_done, then writes back and advances the PC.
// HALT and ERROR are absorbing until reset; halted/illegal/timeout are sticky flags.
module uc_mc #(
    parameter int unsigned OPW      = 8,
    parameter int unsigned ALUOPW   = 8,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OPW-1:0]    IR,
    input  logic              mem_ack,
    input  logic              alu_done,
    output logic              mem_req,
    output logic              ir_load,
    output logic              reg_load_a,
    output logic              reg_load_b,
    output logic              reg_load_c,
    output logic              pc_load,
    output logic              alu_start,
    output logic [ALUOPW-1:0] alu_op,
    output logic              halted,
    output logic              illegal,
    output logic              timeout
);

    // Wide enough to hold WAIT_MAX itself after the final increment.
    localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] StStart  = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;
    localparam logic [2:0] StError  = 3'd6;

    localparam logic [7:0] OpNop  = 8'h00;
    localparam logic [7:0] OpAdd  = 8'h01;
    localparam logic [7:0] OpSub  = 8'h02;
    localparam logic [7:0] OpMul  = 8'h03;
    localparam logic [7:0] OpDiv  = 8'h04;
    localparam logic [7:0] OpMod  = 8'h05;
    localparam logic [7:0] OpCmp  = 8'h1F;
    localparam logic [7:0] OpShl  = 8'h3C;
    localparam logic [7:0] OpShr  = 8'h3D;
    localparam logic [7:0] OpAnd  = 8'h75;
    localparam logic [7:0] OpOr   = 8'h76;
    localparam logic [7:0] OpXor  = 8'h77;
    localparam logic [7:0] OpNot  = 8'h78;
    localparam logic [7:0] OpNand = 8'h79;
    localparam logic [7:0] OpNor  = 8'h7A;
    localparam logic [7:0] OpXnor = 8'h7B;
    localparam logic [7:0] OpHalt = 8'hFF;

    logic [2:0]     state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           halted_q, halted_d;
    logic           illegal_q, illegal_d;
    logic           timeout_q, timeout_d;

    // Decoded view of the latched opcode.
    logic [3:0] dec_code;   // 0 means "not an ALU opcode"
    logic       dec_multi;  // waits on alu_done
    logic       dec_is_nop;
    logic       dec_is_halt;
    logic       dec_is_cmp;

    // Classify the latched opcode; opcodes are compared zero-extended to OPW.
    always_comb begin
        dec_code    = 4'd0;
        dec_multi   = 1'b0;
        dec_is_nop  = (opcode_q == OPW'(OpNop));
        dec_is_halt = (opcode_q == OPW'(OpHalt));
        dec_is_cmp  = (opcode_q == OPW'(OpCmp));
        case (opcode_q)
            OPW'(OpAdd):  dec_code = 4'd1;
            OPW'(OpSub):  dec_code = 4'd2;
            OPW'(OpMul): begin
                dec_code  = 4'd3;
                dec_multi = 1'b1;
            end
            OPW'(OpDiv): begin
                dec_code  = 4'd4;
                dec_multi = 1'b1;
            end
            OPW'(OpMod): begin
                dec_code  = 4'd5;
                dec_multi = 1'b1;
            end
            OPW'(OpAnd):  dec_code = 4'd6;
            OPW'(OpOr):   dec_code = 4'd7;
            OPW'(OpXor):  dec_code = 4'd8;
            OPW'(OpNand): dec_code = 4'd9;
            OPW'(OpNor):  dec_code = 4'd10;
            OPW'(OpXnor): dec_code = 4'd11;
            OPW'(OpCmp):  dec_code = 4'd12;
            OPW'(OpShl):  dec_code = 4'd13;
            OPW'(OpShr):  dec_code = 4'd14;
            OPW'(OpNot):  dec_code = 4'd15;
            default:      dec_code = 4'd0;
        endcase
    end

    // Next-state logic: sequencing, opcode capture, EXEC wait counter and sticky flags.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (mem_ack) begin
                    opcode_d = IR;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Counter is cleared here so it reads zero on the first EXEC cycle.
                cnt_d = '0;
                if (dec_is_nop) begin
                    state_d = StWb;
                end else if (dec_is_halt) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else if (dec_code != 4'd0) begin
                    state_d = StExec;
                end else begin
                    state_d   = StError;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                cnt_d = cnt_q + CntW'(1);
                if (!dec_multi) begin
                    state_d = StWb;
                end else if (alu_done) begin
                    // alu_done wins even on the last allowed wait cycle.
                    state_d = StWb;
                end else if (cnt_q == CntW'(WAIT_MAX - 1)) begin
                    state_d   = StError;
                    timeout_d = 1'b1;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            StError: state_d = StError;
            default: state_d = StStart;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StStart;
            opcode_q  <= '0;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore outputs from state; ir_load also follows mem_ack so the load happens with the ack.
    always_comb begin
        mem_req    = (state_q == StFetch);
        ir_load    = (state_q == StFetch) && mem_ack;
        reg_load_a = (state_q == StDecode);
        reg_load_b = (state_q == StDecode);
        alu_start  = (state_q == StExec) && dec_multi && (cnt_q == '0);
        alu_op     = '0;
        if ((state_q == StExec) || (state_q == StWb)) begin
            alu_op = ALUOPW'(dec_code);
        end
        // NOP has dec_code 0; CMP only sets flags, so no result register write.
        reg_load_c = (state_q == StWb) && (dec_code != 4'd0) && !dec_is_cmp;
        pc_load    = (state_q == StWb);
        halted     = halted_q;
        illegal    = illegal_q;
        timeout    = timeout_q;
    end

endmodule

// File: tb/tb_uc_mc.sv
// tb_uc_mc: randomized self-checking bench for uc_mc.
// A transaction-level model expands each instruction into its expected per-cycle outputs.
module tb_uc_mc;

    localparam int unsigned WaitMax = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IR = '0;
    logic       mem_ack = 1'b0;
    logic       alu_done = 1'b0;
    logic       mem_req, ir_load, reg_load_a, reg_load_b, reg_load_c, pc_load, alu_start;
    logic [7:0] alu_op;
    logic       halted, illegal, timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int          code_tab [256];
    logic [7:0]  legal_ops [15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h75, 8'h76, 8'h77,
                                    8'h79, 8'h7A, 8'h7B, 8'h1F, 8'h3C, 8'h3D, 8'h78};

    uc_mc #(
        .OPW      (8),
        .ALUOPW   (8),
        .WAIT_MAX (WaitMax)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .IR         (IR),
        .mem_ack    (mem_ack),
        .alu_done   (alu_done),
        .mem_req    (mem_req),
        .ir_load    (ir_load),
        .reg_load_a (reg_load_a),
        .reg_load_b (reg_load_b),
        .reg_load_c (reg_load_c),
        .pc_load    (pc_load),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] outs_now();
        return {14'b0, mem_req, ir_load, reg_load_a, reg_load_b, reg_load_c, pc_load,
                alu_start, alu_op, halted, illegal, timeout};
    endfunction

    // Expected output vector; ab covers reg_load_a and reg_load_b together.
    function automatic logic [31:0] mk(input bit mr, input bit il, input bit ab, input bit lc,
                                       input bit pc, input bit st, input int op, input bit h,
                                       input bit ill, input bit to);
        logic [7:0] op8;
        op8 = op[7:0];
        return {14'b0, mr, il, ab, ab, lc, pc, st, op8, h, ill, to};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rop();
        return 8'($urandom_range(0, 255));
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample outputs 1 time unit later.
    task automatic step(input string tag, input bit rst, input bit ack, input logic [7:0] ir,
                        input bit done, input logic [31:0] exp);
        @(negedge clock);
        reset    = rst;
        mem_ack  = ack;
        IR       = ir;
        alu_done = done;
        #1;
        check_eq(tag, outs_now(), exp);
    endtask

    // Reset with noisy inputs (mem_ack high), then expect a quiet START cycle.
    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        mem_ack  = 1'b1;
        IR       = rop();
        alu_done = rb();
        step("start", 1'b0, rb(), rop(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic absorb(input string tag, input bit h, input bit ill, input bit to);
        for (int i = 0; i < 3; i++) begin
            step(tag, 1'b0, rb(), rop(), rb(), mk(0, 0, 0, 0, 0, 0, 0, h, ill, to));
        end
    endtask

    // fate: 0 = back in FETCH, 1 = absorbing state, 2 = reset applied during EXEC (now in START).
    task automatic run_instr(input logic [7:0] op, input int ack_wait, input int done_at,
                             input int abort_at, output int fate);
        int  code;
        bit  multi;
        bit  done_seen;
        bit  dn;
        bit  rst;
        code      = code_tab[op];
        multi     = (op == 8'h03) || (op == 8'h04) || (op == 8'h05);
        done_seen = 1'b0;
        fate      = 0;
        for (int i = 0; i < ack_wait; i++) begin
            step("fetch_wait", 1'b0, 1'b0, rop(), rb(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        step("fetch", 1'b0, 1'b1, op, rb(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("decode", 1'b0, rb(), rop(), rb(), mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        if (op == 8'hFF) begin
            absorb("halt", 1'b1, 1'b0, 1'b0);
            fate = 1;
            return;
        end
        if (op != 8'h00 && code == 0) begin
            absorb("illegal", 1'b0, 1'b1, 1'b0);
            fate = 1;
            return;
        end
        if (op != 8'h00) begin
            if (!multi) begin
                step("exec_single", 1'b0, rb(), rop(), rb(),
                     mk(0, 0, 0, 0, 0, 0, code, 0, 0, 0));
            end else begin
                for (int c = 1; c <= int'(WaitMax) && !done_seen; c++) begin
                    dn  = (c == done_at);
                    rst = (c == abort_at);
                    step("exec_multi", rst, rb(), rop(), dn,
                         mk(0, 0, 0, 0, 0, c == 1, code, 0, 0, 0));
                    if (rst) begin
                        step("start_after_abort", 1'b0, rb(), rop(), rb(),
                             mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                        fate = 2;
                        return;
                    end
                    done_seen = dn;
                end
                if (!done_seen) begin
                    absorb("timeout", 1'b0, 1'b0, 1'b1);
                    fate = 1;
                    return;
                end
            end
        end
        step("wb", 1'b0, rb(), rop(), rb(),
             mk(0, 0, 0, (op != 8'h00) && (op != 8'h1F), 1, 0, code, 0, 0, 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fate;
        int r;
        logic [7:0] op;
        int done_at;
        int abort_at;

        foreach (code_tab[i]) code_tab[i] = 0;
        foreach (legal_ops[i]) code_tab[legal_ops[i]] = i + 1;

        // Directed sequences.
        do_reset();
        run_instr(8'h01, 0, 0, 0, fate);
        run_instr(8'h04, 0, 3, 0, fate);
        run_instr(8'h1F, 0, 0, 0, fate);
        run_instr(8'h00, 0, 0, 0, fate);
        run_instr(8'hFF, 0, 0, 0, fate);
        do_reset();
        run_instr(8'h03, 0, 0, 0, fate);
        do_reset();
        run_instr(8'h42, 5, 0, 0, fate);
        do_reset();
        run_instr(8'h05, 0, 1, 0, fate);
        run_instr(8'h03, 0, int'(WaitMax), 0, fate);
        run_instr(8'h04, 2, 0, 2, fate);

        // Randomized programs.
        for (int p = 0; p < 30; p++) begin
            do_reset();
            for (int n = 0; n < 25; n++) begin
                r        = $urandom_range(0, 99);
                done_at  = $urandom_range(0, WaitMax + 1);
                abort_at = 0;
                if (r < 70) op = legal_ops[$urandom_range(0, 14)];
                else if (r < 80) op = 8'h00;
                else if (r < 88) op = 8'($urandom_range(8'h80, 8'hFE));
                else if (r < 93) op = 8'hFF;
                else begin
                    op       = 8'($urandom_range(3, 5));
                    abort_at = $urandom_range(1, 2);
                    done_at  = 0;
                end
                run_instr(op, $urandom_range(0, 3), done_at, abort_at, fate);
                if (fate != 0) break;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
